// File: rtl/square_seq_checker.sv
// Checks a square-number stream (0,1,4,9,...) after syncing on a zero sample and counts matches/mismatches.
// Latency: one cycle from transfer to registered outputs. Backpressure: in_ready drops only in HALT.
// Optional first-mismatch capture ports are enabled with `define SQCHK_CAPTURE_EN.
module square_seq_checker #(
    parameter int WIDTH     = 32,
    parameter int ERR_CNT_W = 8,
    parameter int ERR_LIMIT = 16,
    parameter int MAX_N     = 65535
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    input  logic                 clr,
    input  logic                 in_valid,
    input  logic [WIDTH-1:0]     in_data,
    output logic                 in_ready,
    output logic                 locked,
    output logic                 done,
    output logic                 err,
    output logic [ERR_CNT_W-1:0] err_cnt,
    output logic [WIDTH-1:0]     match_cnt,
    output logic [WIDTH-1:0]     exp_data
`ifdef SQCHK_CAPTURE_EN
    ,
    output logic                 cap_valid,
    output logic [WIDTH-1:0]     cap_got,
    output logic [WIDTH-1:0]     cap_exp,
    output logic [WIDTH-1:0]     cap_idx
`endif
);

    typedef enum logic [1:0] {IDLE, TRACK, DONE, HALT} state_t;

    state_t               state_q, state_d;
    logic [WIDTH-1:0]     n_q, n_d;
    logic [WIDTH-1:0]     exp_q, exp_d;
    logic [WIDTH-1:0]     match_q, match_d;
    logic [ERR_CNT_W-1:0] errc_q, errc_d;
    logic                 err_q, err_d;
    logic [1:0]           rst_sync;
    logic                 run;
    logic                 xfer;
    logic                 hit;
    logic                 miss_xfer;
    logic [WIDTH-1:0]     n_inc;
    logic [WIDTH-1:0]     exp_inc;
    logic [WIDTH-1:0]     match_inc;
    logic [ERR_CNT_W-1:0] errc_inc;

    // Reset asserts immediately but acceptance waits two edges after release.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) rst_sync <= 2'b00;
        else        rst_sync <= {rst_sync[0], 1'b1};
    end
    assign run = rst_sync[1];

    assign in_ready = (state_q != HALT);
    assign locked   = (state_q == TRACK);
    assign done     = (state_q == DONE);
    assign err      = err_q;
    assign err_cnt  = errc_q;
    assign match_cnt = match_q;
    assign exp_data = exp_q;

    assign xfer      = in_valid && in_ready && run;
    assign hit       = (in_data == exp_q);
    assign miss_xfer = xfer && !clr && (state_q == TRACK) && !hit;
    assign n_inc     = n_q + WIDTH'(1);
    // (n+1)^2 = n^2 + 2n + 1, wrapping naturally at WIDTH bits.
    assign exp_inc   = exp_q + (n_q << 1) + WIDTH'(1);
    assign match_inc = (&match_q) ? match_q : match_q + WIDTH'(1);
    assign errc_inc  = (&errc_q) ? errc_q : errc_q + ERR_CNT_W'(1);

    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        exp_d   = exp_q;
        match_d = match_q;
        errc_d  = errc_q;
        err_d   = err_q;
        if (clr) begin
            state_d = IDLE;
            n_d     = '0;
            exp_d   = '0;
            match_d = '0;
            errc_d  = '0;
            err_d   = 1'b0;
        end else if (xfer) begin
            case (state_q)
                IDLE: begin
                    if (in_data == '0) begin
                        match_d = match_inc;
                        n_d     = WIDTH'(1);
                        exp_d   = WIDTH'(1);
                        state_d = TRACK;
                    end
                end
                TRACK: begin
                    if (hit) begin
                        match_d = match_inc;
                    end else begin
                        err_d  = 1'b1;
                        errc_d = errc_inc;
                    end
                    exp_d = exp_inc;
                    n_d   = n_inc;
                    // The error limit wins over window end on the same sample.
                    if (!hit && errc_inc == ERR_CNT_W'(ERR_LIMIT))
                        state_d = HALT;
                    else if (n_inc == WIDTH'(MAX_N))
                        state_d = DONE;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= IDLE;
            n_q     <= '0;
            exp_q   <= '0;
            match_q <= '0;
            errc_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            exp_q   <= exp_d;
            match_q <= match_d;
            errc_q  <= errc_d;
            err_q   <= err_d;
        end
    end

`ifdef SQCHK_CAPTURE_EN
    // Only the first mismatch since clear/reset is kept.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cap_valid <= 1'b0;
            cap_got   <= '0;
            cap_exp   <= '0;
            cap_idx   <= '0;
        end else if (clr) begin
            cap_valid <= 1'b0;
            cap_got   <= '0;
            cap_exp   <= '0;
            cap_idx   <= '0;
        end else if (miss_xfer && !cap_valid) begin
            cap_valid <= 1'b1;
            cap_got   <= in_data;
            cap_exp   <= exp_q;
            cap_idx   <= n_q;
        end
    end
`endif

endmodule

// File: tb/tb_square_seq_checker.sv
// Randomised and directed bench for square_seq_checker against a square-number reference model.
// Two instances: default parameters, and ERR_LIMIT=2 / MAX_N=4 for the limit and window boundaries.
module tb_square_seq_checker;

    typedef enum {M_IDLE, M_TRACK, M_DONE, M_HALT} mst_t;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b1;
    logic        clr = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_data = '0;

    logic        rdy [2];
    logic        lock[2];
    logic        dn  [2];
    logic        er  [2];
    logic [7:0]  ec  [2];
    logic [31:0] mc  [2];
    logic [31:0] ex  [2];
`ifdef SQCHK_CAPTURE_EN
    logic        cv  [2];
    logic [31:0] cg  [2];
    logic [31:0] ce  [2];
    logic [31:0] ci  [2];
`endif

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state: n is the number of samples consumed since sync.
    int unsigned lim [2] = '{16, 2};
    int unsigned maxn[2] = '{65535, 4};
    mst_t        ms    [2];
    logic [31:0] mn    [2];
    logic [31:0] mmatch[2];
    logic [7:0]  mec   [2];
    logic        merr  [2];
    logic        mcv   [2];
    logic [31:0] mcg   [2];
    logic [31:0] mce   [2];
    logic [31:0] mci   [2];

    always #5 CLK = ~CLK;

    square_seq_checker #(.WIDTH(32), .ERR_CNT_W(8), .ERR_LIMIT(16), .MAX_N(65535)) dut0 (
        .CLK(CLK), .RST_N(RST_N), .clr(clr), .in_valid(in_valid), .in_data(in_data),
        .in_ready(rdy[0]), .locked(lock[0]), .done(dn[0]), .err(er[0]),
        .err_cnt(ec[0]), .match_cnt(mc[0]), .exp_data(ex[0])
`ifdef SQCHK_CAPTURE_EN
        , .cap_valid(cv[0]), .cap_got(cg[0]), .cap_exp(ce[0]), .cap_idx(ci[0])
`endif
    );

    square_seq_checker #(.WIDTH(32), .ERR_CNT_W(8), .ERR_LIMIT(2), .MAX_N(4)) dut1 (
        .CLK(CLK), .RST_N(RST_N), .clr(clr), .in_valid(in_valid), .in_data(in_data),
        .in_ready(rdy[1]), .locked(lock[1]), .done(dn[1]), .err(er[1]),
        .err_cnt(ec[1]), .match_cnt(mc[1]), .exp_data(ex[1])
`ifdef SQCHK_CAPTURE_EN
        , .cap_valid(cv[1]), .cap_got(cg[1]), .cap_exp(ce[1]), .cap_idx(ci[1])
`endif
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s got=%0h want=%0h", tag, got, want);
        end
    endtask

    task automatic model_clear(input int k);
        ms[k] = M_IDLE; mn[k] = '0; mmatch[k] = '0; mec[k] = '0; merr[k] = 1'b0;
        mcv[k] = 1'b0; mcg[k] = '0; mce[k] = '0; mci[k] = '0;
    endtask

    task automatic model_step(input logic v, input logic [31:0] d, input logic c);
        logic [31:0] sq;
        for (int k = 0; k < 2; k++) begin
            sq = mn[k] * mn[k];
            if (c) begin
                model_clear(k);
            end else if (v && ms[k] != M_HALT) begin
                if (ms[k] == M_IDLE) begin
                    if (d == 0) begin
                        if (mmatch[k] != 32'hffff_ffff) mmatch[k]++;
                        mn[k] = 1;
                        ms[k] = M_TRACK;
                    end
                end else if (ms[k] == M_TRACK) begin
                    if (d == sq) begin
                        if (mmatch[k] != 32'hffff_ffff) mmatch[k]++;
                    end else begin
                        merr[k] = 1'b1;
                        if (mec[k] != 8'hff) mec[k]++;
                        if (!mcv[k]) begin
                            mcv[k] = 1'b1; mcg[k] = d; mce[k] = sq; mci[k] = mn[k];
                        end
                    end
                    mn[k] = mn[k] + 1;
                    if (d != sq && mec[k] == 8'(lim[k])) ms[k] = M_HALT;
                    else if (mn[k] == maxn[k])           ms[k] = M_DONE;
                end
            end
        end
    endtask

    task automatic check_all(input string tag);
        logic [31:0] sq;
        for (int k = 0; k < 2; k++) begin
            sq = mn[k] * mn[k];
            chk($sformatf("%s.rdy%0d", tag, k),   64'(rdy[k]),  64'(ms[k] != M_HALT));
            chk($sformatf("%s.lock%0d", tag, k),  64'(lock[k]), 64'(ms[k] == M_TRACK));
            chk($sformatf("%s.done%0d", tag, k),  64'(dn[k]),   64'(ms[k] == M_DONE));
            chk($sformatf("%s.err%0d", tag, k),   64'(er[k]),   64'(merr[k]));
            chk($sformatf("%s.ecnt%0d", tag, k),  64'(ec[k]),   64'(mec[k]));
            chk($sformatf("%s.mcnt%0d", tag, k),  64'(mc[k]),   64'(mmatch[k]));
            chk($sformatf("%s.exp%0d", tag, k),   64'(ex[k]),   64'(sq));
`ifdef SQCHK_CAPTURE_EN
            chk($sformatf("%s.cv%0d", tag, k),    64'(cv[k]),   64'(mcv[k]));
            chk($sformatf("%s.cg%0d", tag, k),    64'(cg[k]),   64'(mcg[k]));
            chk($sformatf("%s.ce%0d", tag, k),    64'(ce[k]),   64'(mce[k]));
            chk($sformatf("%s.ci%0d", tag, k),    64'(ci[k]),   64'(mci[k]));
`endif
        end
    endtask

    task automatic cycle(input string tag, input logic v, input logic [31:0] d, input logic c);
        in_valid = v; in_data = d; clr = c;
        model_step(v, d, c);
        @(posedge CLK);
        #1;
        check_all(tag);
    endtask

    // Called between clock edges; checks outputs go to reset values with no edge.
    task automatic do_reset(input string tag);
        RST_N = 1'b0; in_valid = 1'b0; clr = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) model_clear(k);
        check_all({tag, ".async"});
        chk({tag, ".rdy_in_rst"}, 64'(rdy[0]), 64'd1);
        #1;
        RST_N = 1'b1;
        in_valid = 1'b1; in_data = '0;
        @(posedge CLK);
        #1;
        chk({tag, ".first_edge_lock0"}, 64'(lock[0]), 64'd0);
        chk({tag, ".first_edge_mcnt1"}, 64'(mc[1]), 64'd0);
        in_valid = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        check_all({tag, ".settled"});
    endtask

    initial begin
        logic [31:0] d;
        logic        v, c;
        #2;
        do_reset("init");

        // Clean square stream
        cycle("s0", 1, 0, 0);
        chk("s0.locked", 64'(lock[0]), 64'd1);
        cycle("s1", 1, 1, 0);
        cycle("s4", 1, 4, 0);
        cycle("s9", 1, 9, 0);
        cycle("s16", 1, 16, 0);
        chk("clean.mcnt", 64'(mc[0]), 64'd5);
        chk("clean.exp", 64'(ex[0]), 64'd25);
        chk("clean.err", 64'(er[0]), 64'd0);

        // Discard before sync
        cycle("clr_a", 0, 0, 1);
        cycle("idle7", 1, 7, 0);
        chk("idle7.lock", 64'(lock[0]), 64'd0);
        cycle("idle3", 1, 3, 0);
        cycle("idle0", 1, 0, 0);
        cycle("idle1", 1, 1, 0);
        chk("idle.mcnt", 64'(mc[0]), 64'd2);
        chk("idle.ecnt", 64'(ec[0]), 64'd0);

        // Single mismatch
        cycle("clr_b", 0, 0, 1);
        cycle("m0", 1, 0, 0);
        cycle("m1", 1, 1, 0);
        cycle("m5", 1, 5, 0);
        cycle("m9", 1, 9, 0);
        chk("mis.err", 64'(er[0]), 64'd1);
        chk("mis.ecnt", 64'(ec[0]), 64'd1);
        chk("mis.mcnt", 64'(mc[0]), 64'd3);
        chk("mis.exp", 64'(ex[0]), 64'd16);
`ifdef SQCHK_CAPTURE_EN
        chk("mis.cap_got", 64'(cg[0]), 64'd5);
        chk("mis.cap_exp", 64'(ce[0]), 64'd4);
        chk("mis.cap_idx", 64'(ci[0]), 64'd2);
`endif

        // Error limit on dut1
        cycle("clr_c", 0, 0, 1);
        cycle("h0", 1, 0, 0);
        cycle("h2", 1, 2, 0);
        cycle("h3", 1, 3, 0);
        chk("halt.rdy", 64'(rdy[1]), 64'd0);
        chk("halt.ecnt", 64'(ec[1]), 64'd2);
        cycle("halt_ignore", 1, 0, 0);
        cycle("halt_clr", 0, 0, 1);
        chk("halt_clr.rdy", 64'(rdy[1]), 64'd1);
        chk("halt_clr.ecnt", 64'(ec[1]), 64'd0);

        // Window end on dut1
        cycle("d0", 1, 0, 0);
        cycle("d1", 1, 1, 0);
        cycle("d4", 1, 4, 0);
        cycle("d9", 1, 9, 0);
        chk("done.flag", 64'(dn[1]), 64'd1);
        chk("done.mcnt", 64'(mc[1]), 64'd4);
        cycle("d16", 1, 16, 0);
        cycle("d99", 1, 99, 0);
        chk("done.err", 64'(er[1]), 64'd0);
        chk("done.mcnt_frozen", 64'(mc[1]), 64'd4);

        // Async reset mid-TRACK, then clr beating a valid zero
        cycle("clr_d", 0, 0, 1);
        cycle("t0", 1, 0, 0);
        cycle("t1", 1, 1, 0);
        do_reset("midtrack");
        chk("midtrack.mcnt", 64'(mc[0]), 64'd0);
        cycle("clr_vs_valid", 1, 0, 1);
        chk("clr_vs_valid.lock", 64'(lock[0]), 64'd0);
        chk("clr_vs_valid.mcnt", 64'(mc[0]), 64'd0);

        // Randomised stream
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 999) == 0) begin
                do_reset("rnd_rst");
            end else begin
                v = ($urandom_range(0, 3) != 0);
                c = ($urandom_range(0, 149) == 0);
                if (ms[0] == M_TRACK)
                    d = ($urandom_range(0, 19) == 0) ? $urandom : mn[0] * mn[0];
                else if (ms[0] == M_IDLE)
                    d = ($urandom_range(0, 2) == 0) ? 32'd0 : $urandom;
                else
                    d = $urandom;
                cycle("rnd", v, d, c);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/square_seq_checker.md
SQUARE_SEQ_CHECKER -- requirements
Module: square_seq_checker

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, sample and expectation width.
REQ-002 The block SHALL have parameter ERR_CNT_W, default 8, width of the mismatch counter.
REQ-003 The block SHALL have parameter ERR_LIMIT, default 16, mismatch count that forces HALT (1..2^ERR_CNT_W-1).
REQ-004 The block SHALL have parameter MAX_N, default 65535, number of samples after sync at which checking ends (overflow-free window).
REQ-005 The block SHALL have port CLK  input  1  single clock, rising edge.
REQ-006 The block SHALL have port RST_N  input  1  reset, asynchronous, active-low.
REQ-007 The block SHALL have port clr  input  1  synchronous clear to IDLE.
REQ-008 The block SHALL have port in_valid  input  1  sample offered.
REQ-009 The block SHALL have port in_data  input  WIDTH  sample from the square-sequence generator.
REQ-010 The block SHALL have port in_ready  output  1  sample accepted when high with in_valid.
REQ-011 The block SHALL have port locked  output  1  state is TRACK.
REQ-012 The block SHALL have port done  output  1  state is DONE.
REQ-013 The block SHALL have port err  output  1  sticky, any mismatch since clear.
REQ-014 The block SHALL have port err_cnt  output  ERR_CNT_W  mismatch count.
REQ-015 The block SHALL have port match_cnt  output  WIDTH  matching-sample count.
REQ-016 The block SHALL have port exp_data  output  WIDTH  expected value of the next sample.

Function
REQ-017 A transfer SHALL be in_valid && in_ready on a rising CLK edge; all outputs are registered and reflect a transfer one cycle after it.
REQ-018 States SHALL be IDLE, TRACK, DONE, HALT; in_ready SHALL be 1 in IDLE/TRACK/DONE and 0 in HALT.
REQ-019 IDLE: transfer with in_data==0 SHALL count as a match, set n=1, exp_data=1, go TRACK; nonzero samples are discarded with no counter change.
REQ-020 TRACK: each transfer SHALL compare in_data to exp_data; match increments match_cnt; mismatch sets err and increments err_cnt.
REQ-021 TRACK: after every transfer, match or not, exp_data SHALL become exp_data+2n+1 and n SHALL become n+1, modulo 2^WIDTH.
REQ-022 TRACK SHALL go DONE when the post-transfer n equals MAX_N; DONE accepts and discards samples, counters frozen.
REQ-023 TRACK SHALL go HALT when err_cnt reaches ERR_LIMIT on that transfer; HALT takes priority over DONE on the same transfer.
REQ-024 err_cnt SHALL saturate at all-ones; match_cnt SHALL saturate at all-ones.
REQ-025 clr SHALL return to IDLE, zero all counters, err, exp_data and n; clr coincident with in_valid SHALL win and drop the sample.
REQ-026 HALT SHALL be left only by clr or RST_N.

Reset
REQ-027 RST_N low SHALL immediately force IDLE, in_ready=1, locked=0, done=0, err=0, err_cnt=0, match_cnt=0, exp_data=0, n=0, including mid-TRACK.
REQ-028 Release of RST_N SHALL be synchronised so the first transfer is accepted no earlier than the second CLK edge after deassertion.

Configuration
REQ-029 With macro SQCHK_CAPTURE_EN defined, ports cap_valid (1), cap_got (WIDTH), cap_exp (WIDTH), cap_idx (WIDTH) SHALL exist and capture the first mismatch (sample, expectation, n at that sample); they hold until clr/reset, reset value 0.
REQ-030 Without SQCHK_CAPTURE_EN, those ports and registers SHALL be absent and all other behaviour identical.

Verification
REQ-031 Reset, stream 0,1,4,9,16 -> locked=1 after first, match_cnt=5, err=0, exp_data=25.
REQ-032 IDLE stream 7,3,0,1 -> locked rises only after the 0, match_cnt=2, err_cnt=0.
REQ-033 Stream 0,1,5,9 -> err=1, err_cnt=1, match_cnt=3, exp_data=16; with SQCHK_CAPTURE_EN cap_got=5, cap_exp=4, cap_idx=2.
REQ-034 ERR_LIMIT=2, stream 0,2,3 -> HALT after third sample, in_ready=0, err_cnt=2; clr -> IDLE, in_ready=1, counters 0.
REQ-035 MAX_N=4, stream 0,1,4,9,16,99 -> done=1 after 9, match_cnt=4, err=0 unchanged by later samples.
REQ-036 RST_N pulsed low mid-TRACK without a CLK edge -> outputs at reset values immediately; clr with in_valid, in_data=0 in IDLE -> stays IDLE, match_cnt=0.
